// File: rtl/instr_pipe_ctrl.sv
// Drives the OF/EX/MA/WB instruction latches that the forwarding unit and the stage datapaths read.
// Shifts one instruction per cycle, inserts one bubble on a load-use hazard, and squashes on a taken branch.
module instr_pipe_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h6800_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_IF,
    input  logic             branch_taken_EX,
    output logic [31:0]      instruction_OF,
    output logic [31:0]      instruction_EX,
    output logic [31:0]      instruction_MA,
    output logic [31:0]      instruction_WB,
    output logic             stall_IF,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [4:0]       OP_LD   = 5'b01110;
    localparam logic [4:0]       OP_ST   = 5'b01111;
    localparam logic [4:0]       OP_RET  = 5'b10100;
    localparam logic [3:0]       REG_RA  = 4'd15;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [4:0] of_op;
    logic [4:0] ex_op;
    logic       of_imm;
    logic [3:0] of_rs1;
    logic [3:0] of_rs2;
    logic [3:0] ex_rd;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       reads_ra;
    logic       load_use;
    logic       flush;

    assign of_op  = instruction_OF[31:27];
    assign of_imm = instruction_OF[26];
    assign of_rs1 = instruction_OF[21:18];
    assign of_rs2 = instruction_OF[17:14];
    assign ex_op  = instruction_EX[31:27];
    assign ex_rd  = instruction_EX[25:22];

    // A store's data register (rd field) is deliberately not a hazard source: the WB->MA forward covers it.
    assign reads_rs1 = (of_op <= 5'b00111)
                     || ((of_op >= 5'b01010) && (of_op <= 5'b01100))
                     || (of_op == OP_LD)
                     || (of_op == OP_ST);
    assign reads_rs2 = !of_imm && (of_op <= 5'b01100);
    assign reads_ra  = (of_op == OP_RET);

    assign load_use = (ex_op == OP_LD)
                   && ((reads_rs1 && (of_rs1 == ex_rd))
                    || (reads_rs2 && (of_rs2 == ex_rd))
                    || (reads_ra  && (ex_rd == REG_RA)));

    assign flush    = branch_taken_EX;
    assign stall_IF = load_use && !flush && !rst;

    // Flush beats stall; MA and WB shift unconditionally since memory never back-pressures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_OF <= NOP_INSTR;
            instruction_EX <= NOP_INSTR;
            instruction_MA <= NOP_INSTR;
            instruction_WB <= NOP_INSTR;
            stall_count    <= '0;
            flush_count    <= '0;
        end else begin
            instruction_MA <= instruction_EX;
            instruction_WB <= instruction_MA;
            if (flush) begin
                instruction_OF <= NOP_INSTR;
                instruction_EX <= NOP_INSTR;
                if (flush_count != CNT_MAX) begin
                    flush_count <= flush_count + CNT_W'(1);
                end
            end else if (load_use) begin
                instruction_EX <= NOP_INSTR;
                if (stall_count != CNT_MAX) begin
                    stall_count <= stall_count + CNT_W'(1);
                end
            end else begin
                instruction_OF <= instr_IF;
                instruction_EX <= instruction_OF;
            end
        end
    end

endmodule

// File: tb/tb_instr_pipe_ctrl.sv
// Scoreboard bench for instr_pipe_ctrl: each driven cycle queues its expected pipeline snapshot,
// and a monitor on the falling edge pops it and compares it against the DUT.
module tb_instr_pipe_ctrl;

    localparam int CW = 8;

    localparam logic [31:0] NOP    = 32'h6800_0000;
    localparam logic [31:0] ADD    = 32'h0048_4C00;
    localparam logic [31:0] SUB    = {5'b00001, 1'b0, 4'd6,  4'd7, 4'd8,  14'd0};
    localparam logic [31:0] MUL    = {5'b00010, 1'b0, 4'd9,  4'd10, 4'd11, 14'd0};
    localparam logic [31:0] LD1    = 32'h7048_0004;
    localparam logic [31:0] LD3    = {5'b01110, 1'b0, 4'd3,  4'd2, 4'd0,  14'd0};
    localparam logic [31:0] LD15   = {5'b01110, 1'b0, 4'd15, 4'd2, 4'd0,  14'd0};
    localparam logic [31:0] LD2R1  = {5'b01110, 1'b0, 4'd2,  4'd1, 4'd0,  14'd0};
    localparam logic [31:0] LDC    = {5'b01110, 1'b0, 4'd1,  4'd1, 4'd0,  14'd0};
    localparam logic [31:0] ADD415 = {5'b00000, 1'b0, 4'd4,  4'd1, 4'd5,  14'd0};
    localparam logic [31:0] ADDI   = {5'b00000, 1'b1, 4'd4,  4'd5, 4'd3,  14'd5};
    localparam logic [31:0] ST     = {5'b01111, 1'b0, 4'd1,  4'd6, 4'd0,  14'd0};
    localparam logic [31:0] RET    = {5'b10100, 1'b0, 4'd0,  4'd0, 4'd0,  14'd0};
    localparam logic [31:0] ADD322 = {5'b00000, 1'b0, 4'd3,  4'd2, 4'd2,  14'd0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr_IF = NOP;
    logic          branch_taken_EX = 1'b0;
    logic [31:0]   instruction_OF;
    logic [31:0]   instruction_EX;
    logic [31:0]   instruction_MA;
    logic [31:0]   instruction_WB;
    logic          stall_IF;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    typedef struct {
        int          id;
        logic [2:0]  mask;
        logic [31:0] of_i;
        logic [31:0] ex_i;
        logic [31:0] ma_i;
        logic [31:0] wb_i;
        logic        stall;
        int          sc;
        int          fc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    instr_pipe_ctrl #(.NOP_INSTR(32'h6800_0000), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_IF       (instr_IF),
        .branch_taken_EX(branch_taken_EX),
        .instruction_OF (instruction_OF),
        .instruction_EX (instruction_EX),
        .instruction_MA (instruction_MA),
        .instruction_WB (instruction_WB),
        .stall_IF       (stall_IF),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL v%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge and queue what the DUT must show during that cycle.
    task automatic applyStimulus(input int id, input logic r, input logic [31:0] ins, input logic b,
                                 input logic [2:0] mask,
                                 input logic [31:0] eof, input logic [31:0] eex,
                                 input logic [31:0] ema, input logic [31:0] ewb,
                                 input logic est, input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        instr_IF        = ins;
        branch_taken_EX = b;
        e.id = id; e.mask = mask;
        e.of_i = eof; e.ex_i = eex; e.ma_i = ema; e.wb_i = ewb;
        e.stall = est; e.sc = esc; e.fc = efc;
        if (mask != 3'b000) sb.push_back(e);
    endtask

    task automatic driveOnly(input logic [31:0] ins, input logic b, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst             = 1'b0;
            instr_IF        = ins;
            branch_taken_EX = b;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.mask[2]) begin
                checkOutput(e.id, "instruction_OF", instruction_OF, e.of_i);
                checkOutput(e.id, "instruction_EX", instruction_EX, e.ex_i);
                checkOutput(e.id, "instruction_MA", instruction_MA, e.ma_i);
                checkOutput(e.id, "instruction_WB", instruction_WB, e.wb_i);
            end
            if (e.mask[1]) checkOutput(e.id, "stall_IF", 32'(stall_IF), 32'(e.stall));
            if (e.mask[0]) begin
                checkOutput(e.id, "stall_count", 32'(stall_count), e.sc);
                checkOutput(e.id, "flush_count", 32'(flush_count), e.fc);
            end
        end
    end

    initial begin
        // Reset, then a plain add/sub/mul walk through all four stages.
        applyStimulus( 0, 1, ADD,    0, 3'b111, NOP,    NOP,    NOP,    NOP,    0, 0, 0);
        applyStimulus( 1, 0, ADD,    0, 3'b111, NOP,    NOP,    NOP,    NOP,    0, 0, 0);
        applyStimulus( 2, 0, SUB,    0, 3'b111, ADD,    NOP,    NOP,    NOP,    0, 0, 0);
        applyStimulus( 3, 0, MUL,    0, 3'b111, SUB,    ADD,    NOP,    NOP,    0, 0, 0);
        applyStimulus( 4, 0, NOP,    0, 3'b111, MUL,    SUB,    ADD,    NOP,    0, 0, 0);
        applyStimulus( 5, 0, NOP,    0, 3'b111, NOP,    MUL,    SUB,    ADD,    0, 0, 0);
        // Load-use on rs1: one bubble, OF held.
        applyStimulus( 6, 0, LD1,    0, 3'b111, NOP,    NOP,    MUL,    SUB,    0, 0, 0);
        applyStimulus( 7, 0, ADD415, 0, 3'b111, LD1,    NOP,    NOP,    MUL,    0, 0, 0);
        applyStimulus( 8, 0, SUB,    0, 3'b111, ADD415, LD1,    NOP,    NOP,    1, 0, 0);
        applyStimulus( 9, 0, SUB,    0, 3'b111, ADD415, NOP,    LD1,    NOP,    0, 1, 0);
        // Immediate form ignores the rs2 field; store data is not a hazard.
        applyStimulus(10, 0, LD3,    0, 3'b111, SUB,    ADD415, NOP,    LD1,    0, 1, 0);
        applyStimulus(11, 0, ADDI,   0, 3'b111, LD3,    SUB,    ADD415, NOP,    0, 1, 0);
        applyStimulus(12, 0, LD1,    0, 3'b111, ADDI,   LD3,    SUB,    ADD415, 0, 1, 0);
        applyStimulus(13, 0, ST,     0, 3'b111, LD1,    ADDI,   LD3,    SUB,    0, 1, 0);
        applyStimulus(14, 0, LD1,    0, 3'b111, ST,     LD1,    ADDI,   LD3,    0, 1, 0);
        // Flush coinciding with a load-use hazard.
        applyStimulus(15, 0, ADD415, 0, 3'b111, LD1,    ST,     LD1,    ADDI,   0, 1, 0);
        applyStimulus(16, 0, MUL,    1, 3'b111, ADD415, LD1,    ST,     LD1,    0, 1, 0);
        applyStimulus(17, 0, LD15,   0, 3'b111, NOP,    NOP,    LD1,    ST,     0, 1, 1);
        // ret depends on r15.
        applyStimulus(18, 0, RET,    0, 3'b111, LD15,   NOP,    NOP,    LD1,    0, 1, 1);
        applyStimulus(19, 0, SUB,    0, 3'b111, RET,    LD15,   NOP,    NOP,    1, 1, 1);
        applyStimulus(20, 0, SUB,    0, 3'b111, RET,    NOP,    LD15,   NOP,    0, 2, 1);
        // Back-to-back dependent loads, then a two-source consumer.
        applyStimulus(21, 0, LD1,    0, 3'b111, SUB,    RET,    NOP,    LD15,   0, 2, 1);
        applyStimulus(22, 0, LD2R1,  0, 3'b111, LD1,    SUB,    RET,    NOP,    0, 2, 1);
        applyStimulus(23, 0, ADD322, 0, 3'b111, LD2R1,  LD1,    SUB,    RET,    1, 2, 1);
        applyStimulus(24, 0, ADD322, 0, 3'b111, LD2R1,  NOP,    LD1,    SUB,    0, 3, 1);
        applyStimulus(25, 0, NOP,    0, 3'b111, ADD322, LD2R1,  NOP,    LD1,    1, 3, 1);
        applyStimulus(26, 0, NOP,    0, 3'b111, ADD322, NOP,    LD2R1,  NOP,    0, 4, 1);
        applyStimulus(27, 0, LDC,    0, 3'b111, NOP,    ADD322, NOP,    LD2R1,  0, 4, 1);
        // Self-dependent load chain stalls every other cycle; run it past counter saturation.
        driveOnly(LDC, 0, 19);
        applyStimulus(28, 0, LDC,    0, 3'b111, LDC,    LDC,    NOP,    LDC,    1, 13, 1);
        driveOnly(LDC, 0, 600);
        driveOnly(NOP, 0, 3);
        applyStimulus(29, 0, NOP,    0, 3'b001, NOP,    NOP,    NOP,    NOP,    0, 255, 1);
        applyStimulus(30, 0, NOP,    1, 3'b010, NOP,    NOP,    NOP,    NOP,    0, 0, 0);
        driveOnly(NOP, 1, 300);
        driveOnly(NOP, 0, 3);
        // Both counters pinned; then reset while a bubble sits in EX.
        applyStimulus(31, 0, LD1,    0, 3'b111, NOP,    NOP,    NOP,    NOP,    0, 255, 255);
        applyStimulus(32, 0, ADD415, 0, 3'b111, LD1,    NOP,    NOP,    NOP,    0, 255, 255);
        applyStimulus(33, 0, SUB,    0, 3'b111, ADD415, LD1,    NOP,    NOP,    1, 255, 255);
        applyStimulus(34, 1, SUB,    0, 3'b111, NOP,    NOP,    NOP,    NOP,    0, 0, 0);
        applyStimulus(35, 0, MUL,    0, 3'b111, NOP,    NOP,    NOP,    NOP,    0, 0, 0);
        applyStimulus(36, 0, NOP,    0, 3'b111, MUL,    NOP,    NOP,    NOP,    0, 0, 0);
        applyStimulus(37, 0, NOP,    0, 3'b111, NOP,    MUL,    NOP,    NOP,    0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
